// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Bundles the hazard/redirect inputs, the instruction-memory handshake and
//   the IF/ID-facing outputs of the instruction-fetch stage.
//
//   Signals:
//     stall_i          ID cannot accept this cycle
//     redirect_i       taken branch/jump this cycle
//     redirectAddr_i   redirect target (bits [1:0] ignored)
//     imem_req_o       fetch request to instruction memory
//     imem_addr_o      fetch address (the PC)
//     imem_ack_i       single-cycle data-return pulse from memory
//     imem_data_i      instruction word, valid with imem_ack_i
//     valid_o          output buffer holds an instruction for ID
//     nextInstrAddr_o  PC+4 of the buffered instruction (0 when empty)
//     instr_o          buffered instruction (0 when empty)
//
//   Modports:
//     master  the fetch unit itself
//     slave   the surrounding pipeline / memory model
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirectAddr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        valid_o;
    logic [31:0] nextInstrAddr_o;
    logic [31:0] instr_o;

    modport master (
        input  stall_i,
        input  redirect_i,
        input  redirectAddr_i,
        input  imem_ack_i,
        input  imem_data_i,
        output imem_req_o,
        output imem_addr_o,
        output valid_o,
        output nextInstrAddr_o,
        output instr_o
    );

    modport slave (
        output stall_i,
        output redirect_i,
        output redirectAddr_i,
        output imem_ack_i,
        output imem_data_i,
        input  imem_req_o,
        input  imem_addr_o,
        input  valid_o,
        input  nextInstrAddr_o,
        input  instr_o
    );

endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, fetches from instruction memory over
//   a variable-latency req/ack handshake, holds the returned word in a
//   one-entry buffer for IF/ID, and follows stalls and branch/jump redirects
//   (including redirects that land while a fetch is outstanding).
//
//   Parameters:
//     RESET_PC   PC loaded at reset; address of the first fetch
//
//   Ports:
//     clk_i      clock, all state changes on the rising edge
//     rst_i      asynchronous, active-low reset
//     bus        if_fetch_unit_if.master (handshake, redirect and IF/ID side)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    if_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [31:0] r_pc;
    logic [31:0] w_nextPc;
    logic [31:0] r_bufInstr;
    logic [31:0] w_nextBufInstr;
    logic [31:0] r_bufPc4;
    logic [31:0] w_nextBufPc4;
    logic        r_bufValid;
    logic        w_nextBufValid;
    logic        r_kill;
    logic        w_nextKill;
    logic [31:0] r_tgt;
    logic [31:0] w_nextTgt;
    logic        r_req;

    logic [31:0] w_redirectTarget;
    logic [31:0] w_pcPlus4;
    logic        w_consume;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign w_redirectTarget = {bus.redirectAddr_i[31:2], 2'b00};

    // Wraps modulo 2^32 with no overflow indication.
    assign w_pcPlus4 = r_pc + 32'd4;

    // ID takes the buffered instruction this cycle. A redirect is not a
    // consume: it flushes the buffer instead.
    assign w_consume = r_bufValid & ~bus.stall_i & ~bus.redirect_i;

    // Next-state and datapath update. Everything holds by default.
    // In REQ the address must not move until the ack arrives, so a redirect
    // seen mid-fetch is parked in r_tgt with r_kill set; the ack that ends
    // that fetch is then thrown away and the PC jumps to the parked target.
    always_comb begin
        w_nextState    = r_state;
        w_nextPc       = r_pc;
        w_nextBufInstr = r_bufInstr;
        w_nextBufPc4   = r_bufPc4;
        w_nextBufValid = r_bufValid;
        w_nextKill     = r_kill;
        w_nextTgt      = r_tgt;

        unique case (r_state)
            ST_START: begin
                w_nextState = ST_REQ;
                if (bus.redirect_i) begin
                    w_nextPc = w_redirectTarget;
                end
            end

            ST_REQ: begin
                if (bus.imem_ack_i) begin
                    if (bus.redirect_i) begin
                        w_nextPc   = w_redirectTarget;
                        w_nextKill = 1'b0;
                    end else if (r_kill) begin
                        w_nextPc   = r_tgt;
                        w_nextKill = 1'b0;
                    end else begin
                        w_nextBufInstr = bus.imem_data_i;
                        w_nextBufPc4   = w_pcPlus4;
                        w_nextBufValid = 1'b1;
                        w_nextPc       = w_pcPlus4;
                        w_nextState    = ST_HOLD;
                    end
                end else if (bus.redirect_i) begin
                    w_nextKill = 1'b1;
                    w_nextTgt  = w_redirectTarget;
                end
            end

            ST_HOLD: begin
                if (bus.redirect_i) begin
                    w_nextBufValid = 1'b0;
                    w_nextPc       = w_redirectTarget;
                    w_nextState    = ST_REQ;
                end else if (w_consume) begin
                    w_nextBufValid = 1'b0;
                    w_nextState    = ST_REQ;
                end
            end

            default: begin
                w_nextState = ST_START;
            end
        endcase
    end

    // State register. The request line is registered off the next state so
    // memory sees a glitch-free request aligned with the PC update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_START;
            r_pc       <= RESET_PC;
            r_bufInstr <= 32'd0;
            r_bufPc4   <= 32'd0;
            r_bufValid <= 1'b0;
            r_kill     <= 1'b0;
            r_tgt      <= 32'd0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_pc       <= w_nextPc;
            r_bufInstr <= w_nextBufInstr;
            r_bufPc4   <= w_nextBufPc4;
            r_bufValid <= w_nextBufValid;
            r_kill     <= w_nextKill;
            r_tgt      <= w_nextTgt;
            r_req      <= (w_nextState == ST_REQ);
        end
    end

    // An empty buffer presents a bubble: all-zero instruction and address.
    assign bus.imem_req_o      = r_req;
    assign bus.imem_addr_o     = r_pc;
    assign bus.valid_o         = r_bufValid;
    assign bus.instr_o         = r_bufValid ? r_bufInstr : 32'd0;
    assign bus.nextInstrAddr_o = r_bufValid ? r_bufPc4   : 32'd0;

endmodule
